// File: rtl/sram_like_mem.sv
// SRAM-like bus responder backed by a word-organised RAM, fixed latency.
// Define SRAM_LIKE_MEM_RANDOM_STALL_EN to add LFSR-driven addr_ok stalls.
module sram_like_mem #(
  parameter int DEPTH_WORDS     = 1024,
  parameter int LATENCY         = 2,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);

  logic [31:0]        mem_q [DEPTH_WORDS];
  logic [AW-1:0]      idx;
  logic [3:0]         be;
  logic               acc;
  logic               stall;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [LATENCY-1:0] vld_q, vld_d;
  logic [31:0]        dat_q [LATENCY];
  logic [31:0]        dat_d [LATENCY];
  logic               unused_addr;

  assign idx         = addr[AW+1:2];
  assign unused_addr = ^addr[31:AW+2];

`ifdef SRAM_LIKE_MEM_RANDOM_STALL_EN
  logic [15:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = {lfsr_q[14:0],
              lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) lfsr_q <= 16'hACE1;
    else         lfsr_q <= lfsr_d;
  end

  assign stall = lfsr_q[0];
`else
  assign stall = 1'b0;
`endif

  assign addr_ok = resetn && (cnt_q < CW'(MAX_OUTSTANDING)) && !stall;
  assign acc     = req && addr_ok;
  assign data_ok = vld_q[LATENCY-1];
  assign rdata   = dat_q[LATENCY-1];

  always_comb begin
    be = 4'b1111;
    unique case (size)
      2'd0:    be = 4'b0001 << addr[1:0];
      2'd1:    be = addr[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
  end

  // Simultaneous accept and completion leave the count unchanged
  always_comb begin
    cnt_d = cnt_q;
    if (acc && !data_ok)      cnt_d = cnt_q + CW'(1);
    else if (!acc && data_ok) cnt_d = cnt_q - CW'(1);
  end

  always_comb begin
    vld_d    = '0;
    vld_d[0] = acc;
    dat_d[0] = (acc && !wr) ? mem_q[idx] : 32'h0;
    for (int i = 1; i < LATENCY; i++) begin
      vld_d[i] = vld_q[i-1];
      dat_d[i] = dat_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '0;
      vld_q <= '0;
      for (int i = 0; i < LATENCY; i++) dat_q[i] <= 32'h0;
    end else begin
      cnt_q <= cnt_d;
      vld_q <= vld_d;
      for (int i = 0; i < LATENCY; i++) dat_q[i] <= dat_d[i];
    end
  end

  // RAM contents survive reset; acc is already gated by resetn
  always_ff @(posedge clk) begin
    if (acc && wr) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem_q[idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_sram_like_mem.sv
// Directed self-checking bench for sram_like_mem (defaults 2/2).
// With SRAM_LIKE_MEM_RANDOM_STALL_EN only the stall scenario runs.
module tb_sram_like_mem;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        req = 1'b0;
  logic        wr = 1'b0;
  logic [1:0]  size = 2'd0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  int n_vec = 0;
  int n_err = 0;

  sram_like_mem dut (
    .clk     (clk),
    .resetn  (resetn),
    .req     (req),
    .wr      (wr),
    .size    (size),
    .addr    (addr),
    .wdata   (wdata),
    .addr_ok (addr_ok),
    .data_ok (data_ok),
    .rdata   (rdata)
  );

  always #5 clk = ~clk;

  // Issues one request, returns cycles from accept to data_ok (-1 on timeout)
  task automatic do_req(input logic w, input logic [1:0] s,
                        input logic [31:0] a, input logic [31:0] d,
                        output int lat, output logic [31:0] rd);
    bit acc;
    bit got;
    acc = 1'b0;
    got = 1'b0;
    lat = -1;
    rd  = 32'hDEAD_DEAD;
    req = 1'b1; wr = w; size = s; addr = a; wdata = d;
    for (int k = 0; k < 20 && !acc; k++) begin
      @(negedge clk);
      acc = addr_ok;
      @(posedge clk); #1;
    end
    req = 1'b0;
    for (int k = 1; k <= 10 && acc && !got; k++) begin
      @(negedge clk);
      if (data_ok) begin
        got = 1'b1;
        lat = k;
        rd  = rdata;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if (addr_ok !== 1'b0) begin
      n_err++; $display("FAIL rst_addr_ok: got %b want 0", addr_ok);
    end
    n_vec++;
    if (data_ok !== 1'b0) begin
      n_err++; $display("FAIL rst_data_ok: got %b want 0", data_ok);
    end
    n_vec++;
    if (rdata !== 32'h0) begin
      n_err++; $display("FAIL rst_rdata: got %h want 0", rdata);
    end
    @(posedge clk); #1;
    resetn = 1'b1;
    @(negedge clk);
    n_vec++;
`ifdef SRAM_LIKE_MEM_RANDOM_STALL_EN
    if (addr_ok !== 1'b0) begin
      n_err++; $display("FAIL rel_addr_ok: got %b want 0", addr_ok);
    end
`else
    if (addr_ok !== 1'b1) begin
      n_err++; $display("FAIL rel_addr_ok: got %b want 1", addr_ok);
    end
`endif
    @(posedge clk); #1;
  endtask

  task automatic test_word();
    int lat;
    logic [31:0] rd;
    do_req(1'b1, 2'd2, 32'h10, 32'h1234_5678, lat, rd);
    n_vec++;
    if (lat !== 2) begin
      n_err++; $display("FAIL word_wr_lat: got %0d want 2", lat);
    end
    n_vec++;
    if (rd !== 32'h0) begin
      n_err++; $display("FAIL word_wr_rdata: got %h want 0", rd);
    end
    do_req(1'b0, 2'd2, 32'h10, 32'h0, lat, rd);
    n_vec++;
    if (lat !== 2) begin
      n_err++; $display("FAIL word_rd_lat: got %0d want 2", lat);
    end
    n_vec++;
    if (rd !== 32'h1234_5678) begin
      n_err++; $display("FAIL word_rd: got %h want 12345678", rd);
    end
  endtask

  task automatic test_byte_half();
    int lat;
    logic [31:0] rd;
    do_req(1'b1, 2'd0, 32'h11, 32'h0000_AB00, lat, rd);
    do_req(1'b0, 2'd2, 32'h10, 32'h0, lat, rd);
    n_vec++;
    if (rd !== 32'h1234_AB78) begin
      n_err++; $display("FAIL byte_rd: got %h want 1234ab78", rd);
    end
    do_req(1'b1, 2'd1, 32'h12, 32'hCDEF_0000, lat, rd);
    do_req(1'b0, 2'd2, 32'h10, 32'h0, lat, rd);
    n_vec++;
    if (rd !== 32'hCDEF_AB78) begin
      n_err++; $display("FAIL half_rd: got %h want cdefab78", rd);
    end
    do_req(1'b0, 2'd2, 32'h1010, 32'h0, lat, rd);
    n_vec++;
    if (rd !== 32'hCDEF_AB78) begin
      n_err++; $display("FAIL alias_rd: got %h want cdefab78", rd);
    end
    do_req(1'b1, 2'd3, 32'h20, 32'hA5A5_A5A5, lat, rd);
    do_req(1'b0, 2'd0, 32'h22, 32'h0, lat, rd);
    n_vec++;
    if (rd !== 32'hA5A5_A5A5) begin
      n_err++; $display("FAIL size3_rd: got %h want a5a5a5a5", rd);
    end
    do_req(1'b1, 2'd0, 32'h23, 32'h1100_0000, lat, rd);
    do_req(1'b1, 2'd1, 32'h21, 32'h0000_BEEF, lat, rd);
    do_req(1'b0, 2'd2, 32'h20, 32'h0, lat, rd);
    n_vec++;
    if (rd !== 32'h11A5_BEEF) begin
      n_err++; $display("FAIL lane3_half0_rd: got %h want 11a5beef", rd);
    end
  endtask

  task automatic test_back_to_back();
    logic        exp_ok [5];
    logic [31:0] exp_rd [5];
    exp_ok = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    exp_rd = '{32'h0, 32'h0, 32'h0, 32'hDEAD_BEEF, 32'h0};
    for (int c = 0; c < 5; c++) begin
      req   = (c < 2);
      wr    = (c == 0);
      size  = 2'd2;
      addr  = 32'h30;
      wdata = 32'hDEAD_BEEF;
      @(negedge clk);
      if (c < 2) begin
        n_vec++;
        if (addr_ok !== 1'b1) begin
          n_err++; $display("FAIL b2b_addr_ok c%0d: got %b want 1", c, addr_ok);
        end
      end
      n_vec++;
      if (data_ok !== exp_ok[c] || (exp_ok[c] && rdata !== exp_rd[c])) begin
        n_err++;
        $display("FAIL b2b_data c%0d: got ok=%b rd=%h want ok=%b rd=%h",
                 c, data_ok, rdata, exp_ok[c], exp_rd[c]);
      end
      @(posedge clk); #1;
    end
    req = 1'b0;
  endtask

  task automatic test_backpressure();
    logic exp_aok [8];
    logic exp_dok [8];
    int   acc;
    exp_aok = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    exp_dok = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    acc  = 0;
    wr   = 1'b0;
    size = 2'd2;
    addr = 32'h10;
    for (int c = 0; c < 8; c++) begin
      req = (acc < 4);
      @(negedge clk);
      n_vec++;
      if (addr_ok !== exp_aok[c]) begin
        n_err++; $display("FAIL bp_addr_ok c%0d: got %b want %b", c, addr_ok, exp_aok[c]);
      end
      n_vec++;
      if (data_ok !== exp_dok[c] || (exp_dok[c] && rdata !== 32'hCDEF_AB78)) begin
        n_err++;
        $display("FAIL bp_data c%0d: got ok=%b rd=%h want ok=%b", c, data_ok, rdata, exp_dok[c]);
      end
      if (req && addr_ok) acc++;
      @(posedge clk); #1;
    end
    req = 1'b0;
    n_vec++;
    if (acc !== 4) begin
      n_err++; $display("FAIL bp_accepts: got %0d want 4", acc);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    logic [31:0] rd;
    int dok;
    req = 1'b1; wr = 1'b0; size = 2'd2; addr = 32'h10;
    repeat (2) @(posedge clk);
    #1;
    req = 1'b0;
    resetn = 1'b0;
    #1;
    n_vec++;
    if (addr_ok !== 1'b0 || data_ok !== 1'b0 || rdata !== 32'h0) begin
      n_err++;
      $display("FAIL midrst_out: got aok=%b dok=%b rd=%h want 0 0 0", addr_ok, data_ok, rdata);
    end
    @(posedge clk); #1;
    resetn = 1'b1;
    dok = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (data_ok) dok++;
      @(posedge clk); #1;
    end
    n_vec++;
    if (dok !== 0) begin
      n_err++; $display("FAIL midrst_stale: got %0d data_ok want 0", dok);
    end
    do_req(1'b0, 2'd2, 32'h10, 32'h0, lat, rd);
    n_vec++;
    if (lat !== 2 || rd !== 32'hCDEF_AB78) begin
      n_err++; $display("FAIL midrst_new: got lat=%0d rd=%h want 2 cdefab78", lat, rd);
    end
  endtask

`ifdef SRAM_LIKE_MEM_RANDOM_STALL_EN
  task automatic test_stall();
    logic [31:0] ref_m [8];
    logic [31:0] expq [$];
    logic [15:0] lfsr_m;
    logic [31:0] word;
    logic [31:0] got;
    int          op;
    int          done;
    op   = 0;
    done = 0;
    resetn = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    lfsr_m = 16'hACE1;
    for (int cyc = 0; cyc < 3000 && done < 32; cyc++) begin
      req = (op < 32);
      if (op < 8) begin
        wr = 1'b1; size = 2'd2;
        addr = 32'h100 + 32'(4 * op);
        wdata = 32'h1111_1111 * 32'(op + 1);
      end else if (op < 24) begin
        wr = (op % 3 != 2); size = 2'(op % 4);
        addr = 32'h100 + 32'(((op * 5) % 8) * 4 + (op % 4));
        wdata = 32'hA5C3_0F96 ^ (32'(op) * 32'h0103_0507);
      end else begin
        wr = 1'b0; size = 2'd2;
        addr = 32'h100 + 32'(4 * (op - 24));
      end
      @(negedge clk);
      if (lfsr_m[0]) begin
        n_vec++;
        if (addr_ok !== 1'b0) begin
          n_err++; $display("FAIL stall_gate c%0d: got addr_ok=1 want 0", cyc);
        end
      end
      if (data_ok) begin
        got = (expq.size() > 0) ? expq.pop_front() : 32'hBAD0_BAD0;
        n_vec++;
        if (rdata !== got) begin
          n_err++; $display("FAIL stall_data #%0d: got %h want %h", done, rdata, got);
        end
        done++;
      end
      if (req && addr_ok) begin
        word = ref_m[addr[4:2]];
        expq.push_back(wr ? 32'h0 : word);
        if (wr) begin
          case (size)
            2'd0: word[8*addr[1:0] +: 8] = wdata[8*addr[1:0] +: 8];
            2'd1: word[16*addr[1] +: 16] = wdata[16*addr[1] +: 16];
            default: word = wdata;
          endcase
          ref_m[addr[4:2]] = word;
        end
        op++;
      end
      @(posedge clk);
      lfsr_m = {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
      #1;
    end
    req = 1'b0;
    n_vec++;
    if (done !== 32) begin
      n_err++; $display("FAIL stall_done: got %0d completions want 32", done);
    end
  endtask
`endif

  initial begin
    test_reset();
`ifdef SRAM_LIKE_MEM_RANDOM_STALL_EN
    test_stall();
`else
    test_word();
    test_byte_half();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sram_like_mem.md
Name: sram_like_mem

Overview:
- Responder (slave) end of the SRAM-like bus that the CPU core drives on its inst/data ports: req/wr/size/addr/wdata out, rdata/addr_ok/data_ok back.
- Backs the bus with a word-organised on-chip RAM.
- Fixed access latency and a bounded outstanding-request count.
- Used as the simulation/FPGA memory model behind the core's instruction and data ports, including addr_ok back-pressure.

Parameters:
- DEPTH_WORDS, 1024: RAM depth in 32-bit words, power of two; index = addr[log2(DEPTH_WORDS)+1:2], upper address bits ignored (aliasing).
- LATENCY, 2: cycles from accept edge to data_ok, >=1.
- MAX_OUTSTANDING, 2: max accepted-but-not-completed requests, 1..LATENCY.

Ports:
- clk  in  1  clock, all state on rising edge.
- resetn  in  1  asynchronous active-low reset.
- req  in  1  request valid; held by initiator until addr_ok.
- wr  in  1  1 = write, 0 = read.
- size  in  2  0 = byte, 1 = half, 2 = word, 3 = treated as word.
- addr  in  32  byte address (physical).
- wdata  in  32  write data, already lane-aligned by initiator.
- addr_ok  out  1  request accepted this cycle when req && addr_ok.
- data_ok  out  1  one-cycle completion pulse per accepted request, in order.
- rdata  out  32  read word, valid only while data_ok.

Behaviour:
- Reset (resetn low, async): addr_ok=0, data_ok=0, rdata=0, outstanding count=0, all pipeline valids cleared. RAM contents untouched (zero at sim start).
- Reset mid-operation: in-flight requests dropped silently, no data_ok for them.
- First accept possible in the first cycle after release.
- addr_ok (combinational from registered state): resetn && (count < MAX_OUTSTANDING). No bypass from a same-cycle data_ok.
- Accept: req && addr_ok at a rising edge.
- Write accept: RAM updated at that edge with byte enables:
  - size0: lane addr[1:0].
  - size1: lanes {addr[1],1}/{addr[1],0}, i.e. half addr[1]; addr[0] ignored.
  - size2/3: all four lanes; addr[1:0] ignored.
- Read accept: the word at the index is sampled at the accept edge.
  - Reflects all writes accepted in strictly earlier cycles.
  - Full word returned; initiator extracts byte/half.
- Completion: accepted request enters a LATENCY-stage shift pipeline carrying {valid, rdata}.
  - data_ok and rdata are driven from the last stage, so a request accepted at edge T completes in cycle T+LATENCY.
  - Writes complete with rdata=0.
  - Pipeline always advances; there is no data-side back-pressure.
- Counter: +1 on accept, -1 on data_ok; unchanged when both occur in one cycle.
  - Never exceeds MAX_OUTSTANDING; never underflows.
- Ordering: completions strictly in accept order; one data_ok per accept.
- Inputs other than req are sampled only on accept; changes while addr_ok=0 are ignored.

Optional Feature:
- Macro: SRAM_LIKE_MEM_RANDOM_STALL_EN.
- Defined:
  - 16-bit Fibonacci LFSR (taps 16,14,13,11), reset to 16'hACE1, advances every cycle.
  - addr_ok additionally gated low whenever lfsr[0]==1.
  - Latency, ordering and counter rules unchanged.
- Undefined: no LFSR; addr_ok exactly as above.

Test Plan:
All with defaults LATENCY=2, MAX_OUTSTANDING=2, cycle numbers relative to first req.
- Word write then read: write addr 0x0000_0010 size2 wdata 0x1234_5678, then read 0x10 -> each data_ok exactly 2 cycles after its accept; read rdata=0x1234_5678; write data_ok rdata=0.
- Byte write: from previous state, write addr 0x11 size0 wdata 0x0000_AB00, read 0x10 -> rdata=0x1234_AB78.
- Half write: write addr 0x12 size1 wdata 0xCDEF_0000, read 0x10 -> rdata=0xCDEF_AB78. Aliasing: read 0x0000_1010 (DEPTH 1024) -> same value.
- Back-pressure: req held high for 4 reads of 0x10 -> accepts at cycles 0,1,3,4; addr_ok=0 at cycles 2 and 5; data_ok at cycles 2,3,5,6; count never exceeds 2.
- Reset mid-operation: 2 reads accepted, resetn low in next cycle for 1 cycle -> addr_ok=0, data_ok=0, rdata=0 immediately; no data_ok after release; new read 0x10 completes 2 cycles after its accept.
- With SRAM_LIKE_MEM_RANDOM_STALL_EN: 32 mixed reads/writes, req/addr/wdata held while addr_ok=0 -> all 32 complete in order; final read data matches reference model; addr_ok low on lfsr[0]==1 cycles.
